shift_accumulator: RTL and testbench



---
 rtl/shift_accumulator_pkg.sv | 35 +++
 rtl/shift_accumulator_if.sv | 40 ++++
 rtl/shift_accumulator_core.sv | 26 ++
 rtl/shift_accumulator.sv | 137 +++++++++++++
 tb/tb_shift_accumulator.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/shift_accumulator_pkg.sv
// Shared constants, state encoding and helpers for the bit-serial shift accumulator.
package acc_pkg;

   // Width of the incoming two's-complement partial sum from global_io.
   localparam int DIN_W    = 27;
   // Maximum number of bit-plane beats in one dot product.
   localparam int MAX_BITS = 24;
   // Accumulator / result width: wide enough that MAX_BITS doublings of a DIN_W value cannot overflow.
   localparam int ACC_W    = DIN_W + MAX_BITS;
   // Beat counter width; must be able to hold the value MAX_BITS.
   localparam int CNT_W    = 5;

   // Control states of the accumulator.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Sign-extend a partial sum to the accumulator width.
   function automatic logic [ACC_W-1:0] sext_ps(input logic [DIN_W-1:0] ps);
      return {{(ACC_W-DIN_W){ps[DIN_W-1]}}, ps};
   endfunction

   // Two's-complement negation at accumulator width (modulo 2^ACC_W).
   function automatic logic [ACC_W-1:0] neg_acc(input logic [ACC_W-1:0] v);
      return (~v) + {{(ACC_W-1){1'b0}}, 1'b1};
   endfunction

   // Beat index of the last plane the accumulator will take without in_last.
   function automatic logic [CNT_W-1:0] last_beat_idx();
      return CNT_W'(MAX_BITS - 1);
   endfunction

endpackage

// File: rtl/shift_accumulator_if.sv
// Streaming bus between global_io (partial-sum producer), the shift
// accumulator, and the result consumer.
interface shift_accumulator_if
   import acc_pkg::*;
();

   // Partial-sum stream in.
   logic             in_valid;
   logic             in_ready;
   logic             in_last;
   logic [DIN_W-1:0] partial_sum;

   // Result stream out.
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] nout;

   // Environment side: drives the partial-sum stream and the result ready.
   modport master (
      output in_valid,
      output in_last,
      output partial_sum,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  nout
   );

   // Accumulator side.
   modport slave (
      input  in_valid,
      input  in_last,
      input  partial_sum,
      input  out_ready,
      output in_ready,
      output out_valid,
      output nout
   );

endinterface

// File: rtl/shift_accumulator_core.sv
// Combinational shift-and-add step: acc_next = (acc << 1) +/- sext(partial_sum).
// Kept on its own so a faster adder architecture can be dropped in later.
module shift_add_core
   import acc_pkg::*;
(
   input  logic [ACC_W-1:0] acc_i,
   input  logic [DIN_W-1:0] ps_i,
   input  logic             negate_i,
   output logic [ACC_W-1:0] acc_next_o
);

   logic [ACC_W-1:0] ps_ext_s;
   logic [ACC_W-1:0] term_s;

   // Select the signed term and add it to the doubled accumulator (wraps modulo 2^ACC_W).
   always_comb begin
      ps_ext_s = sext_ps(ps_i);
      if (negate_i) begin
         term_s = neg_acc(ps_ext_s);
      end else begin
         term_s = ps_ext_s;
      end
      acc_next_o = {acc_i[ACC_W-2:0], 1'b0} + term_s;
   end

endmodule

// File: rtl/shift_accumulator.sv
// Bit-serial shift accumulator: folds MSB-first bit-plane partial sums into a
// dot-product result and hands it off under a valid/ready handshake.
module shift_accumulator
   import acc_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    st,
   input  logic                    act_signed,
   shift_accumulator_if.slave      bus,
   output logic [CNT_W-1:0]        bit_cnt,
   output logic                    err_overlen
);

   state_e            state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  nout_q, nout_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              sign_q, sign_d;
   logic              err_q, err_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q, in_ready_d;

   logic              beat_s;
   logic              negate_s;
   logic              final_beat_s;
   logic [ACC_W-1:0]  acc_next_s;

   // The first (MSB) plane of a signed activation carries negative weight.
   assign negate_s = sign_q && (bit_cnt_q == {CNT_W{1'b0}});

   shift_add_core u_core (
      .acc_i      (acc_q),
      .ps_i       (bus.partial_sum),
      .negate_i   (negate_s),
      .acc_next_o (acc_next_s)
   );

   // in_ready is a register that mirrors the ACC state, so acceptance never
   // depends combinationally on in_valid.
   assign beat_s       = bus.in_valid && in_ready_q;
   assign final_beat_s = bus.in_last || (bit_cnt_q == last_beat_idx());

   // Next-state and datapath update; st overrides everything except rst.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      nout_d      = nout_q;
      bit_cnt_d   = bit_cnt_q;
      sign_d      = sign_q;
      err_d       = err_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;

      if (st) begin
         // Abort/restart: any in-flight run or pending result is discarded.
         state_d     = ACC;
         acc_d       = {ACC_W{1'b0}};
         bit_cnt_d   = {CNT_W{1'b0}};
         sign_d      = act_signed;
         err_d       = 1'b0;
         out_valid_d = 1'b0;
         in_ready_d  = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               // Beats and in_last are ignored until a start pulse.
               state_d = IDLE;
            end
            ACC: begin
               if (beat_s) begin
                  acc_d     = acc_next_s;
                  bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                  if (final_beat_s) begin
                     state_d     = DONE;
                     nout_d      = acc_next_s;
                     out_valid_d = 1'b1;
                     in_ready_d  = 1'b0;
                     if (!bus.in_last) begin
                        err_d = 1'b1;
                     end else begin
                        err_d = err_q;
                     end
                  end else begin
                     state_d = ACC;
                  end
               end else begin
                  state_d = ACC;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_d     = IDLE;
                  out_valid_d = 1'b0;
               end else begin
                  state_d = DONE;
               end
            end
            default: begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= {ACC_W{1'b0}};
         nout_q      <= {ACC_W{1'b0}};
         bit_cnt_q   <= {CNT_W{1'b0}};
         sign_q      <= 1'b0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         nout_q      <= nout_d;
         bit_cnt_q   <= bit_cnt_d;
         sign_q      <= sign_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.nout      = nout_q;
   assign bit_cnt       = bit_cnt_q;
   assign err_overlen   = err_q;

endmodule

// File: tb/tb_shift_accumulator.sv
// Directed, table-driven bench for shift_accumulator.
module tb_shift_accumulator;
   import acc_pkg::*;

   logic clk;
   logic rst;
   logic st;
   logic act_signed;
   logic [CNT_W-1:0] bit_cnt;
   logic err_overlen;

   shift_accumulator_if bus();

   shift_accumulator dut (
      .clk         (clk),
      .rst         (rst),
      .st          (st),
      .act_signed  (act_signed),
      .bus         (bus),
      .bit_cnt     (bit_cnt),
      .err_overlen (err_overlen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic                  sgn;
      int                    n;
      logic [3:0][DIN_W-1:0] ps;
      logic [ACC_W-1:0]      exp_nout;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic start(input logic sgn);
      st = 1'b1;
      act_signed = sgn;
      tick();
      st = 1'b0;
   endtask

   task automatic beat(input logic [DIN_W-1:0] ps, input logic last);
      bus.in_valid    = 1'b1;
      bus.partial_sum = ps;
      bus.in_last     = last;
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   logic [ACC_W-1:0] held;

   initial begin
      rst = 1'b1; st = 1'b0; act_signed = 1'b0;
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      bus.partial_sum = {DIN_W{1'b0}}; bus.out_ready = 1'b0;

      vecs[0] = '{1'b0, 2, {27'd0, 27'd0, 27'd5, 27'd3}, 51'd11};
      vecs[1] = '{1'b1, 2, {27'd0, 27'd0, 27'd0, 27'd1}, 51'h7_FFFF_FFFF_FFFE};
      vecs[2] = '{1'b1, 1, {27'd0, 27'd0, 27'd0, 27'd7}, -51'sd7};
      vecs[3] = '{1'b0, 4, {27'd1, 27'd1, 27'd0, 27'd1}, 51'd11};
      vecs[4] = '{1'b1, 4, {27'd1, 27'd0, 27'd1, 27'd1}, -51'sd3};
      vecs[5] = '{1'b0, 2, {27'd0, 27'd0, 27'd2, 27'h7FF_FFFF}, 51'd0};
      vecs[6] = '{1'b0, 3, {27'd0, 27'h3FF_FFFF, 27'h3FF_FFFF, 27'h3FF_FFFF}, 51'd469762041};
      vecs[7] = '{1'b1, 2, {27'd0, 27'd0, 27'd1, 27'h7FF_FFFD}, 51'd7};

      tick(); tick();
      rst = 1'b0;
      check("reset_nout", 64'(bus.nout), 64'd0);
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_in_ready", 64'(bus.in_ready), 64'd0);
      check("reset_bit_cnt", 64'(bit_cnt), 64'd0);
      check("reset_err", 64'(err_overlen), 64'd0);

      // Beats offered in IDLE are ignored.
      beat(27'd9, 1'b1);
      check("idle_beat_out_valid", 64'(bus.out_valid), 64'd0);
      check("idle_beat_bit_cnt", 64'(bit_cnt), 64'd0);

      // Table-driven dot products.
      for (int v = 0; v < 8; v++) begin
         start(vecs[v].sgn);
         check($sformatf("v%0d_in_ready", v), 64'(bus.in_ready), 64'd1);
         for (int b = 0; b < vecs[v].n; b++) begin
            check($sformatf("v%0d_pre_valid%0d", v, b), 64'(bus.out_valid), 64'd0);
            beat(vecs[v].ps[b], b == vecs[v].n - 1);
         end
         check($sformatf("v%0d_out_valid", v), 64'(bus.out_valid), 64'd1);
         check($sformatf("v%0d_nout", v), 64'(bus.nout), 64'(vecs[v].exp_nout));
         check($sformatf("v%0d_bit_cnt", v), 64'(bit_cnt), 64'(vecs[v].n));
         check($sformatf("v%0d_err", v), 64'(err_overlen), 64'd0);
         drain();
         check($sformatf("v%0d_drained", v), 64'(bus.out_valid), 64'd0);
      end

      // Overlength: MAX_BITS beats without in_last.
      start(1'b0);
      for (int b = 0; b < MAX_BITS; b++) begin
         beat(27'd1, 1'b0);
      end
      check("ovl_out_valid", 64'(bus.out_valid), 64'd1);
      check("ovl_nout", 64'(bus.nout), 64'hFF_FFFF);
      check("ovl_err", 64'(err_overlen), 64'd1);
      check("ovl_bit_cnt", 64'(bit_cnt), 64'd24);

      // Backpressure in DONE: result held, beats ignored.
      for (int c = 0; c < 5; c++) begin
         beat(27'd5, 1'b1);
         check("bp_nout", 64'(bus.nout), 64'hFF_FFFF);
         check("bp_out_valid", 64'(bus.out_valid), 64'd1);
         check("bp_in_ready", 64'(bus.in_ready), 64'd0);
         check("bp_bit_cnt", 64'(bit_cnt), 64'd24);
      end
      drain();
      check("bp_idle_out_valid", 64'(bus.out_valid), 64'd0);
      check("bp_idle_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_err_sticky", 64'(err_overlen), 64'd1);
      start(1'b0);
      check("st_clears_err", 64'(err_overlen), 64'd0);

      // Abort mid-ACC: st drops the coincident beat and earlier beats.
      for (int b = 0; b < 3; b++) begin
         beat(27'd7, 1'b0);
      end
      bus.in_valid = 1'b1; bus.partial_sum = 27'd9; bus.in_last = 1'b1;
      start(1'b0);
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      check("abort_bit_cnt", 64'(bit_cnt), 64'd0);
      beat(27'd2, 1'b0);
      beat(27'd2, 1'b1);
      check("abort_nout", 64'(bus.nout), 64'd6);
      check("abort_bit_cnt2", 64'(bit_cnt), 64'd2);

      // st together with out_ready in DONE discards the result and restarts.
      held = bus.nout;
      bus.out_ready = 1'b1;
      start(1'b0);
      bus.out_ready = 1'b0;
      check("st_done_out_valid", 64'(bus.out_valid), 64'd0);
      check("st_done_in_ready", 64'(bus.in_ready), 64'd1);
      check("st_done_bit_cnt", 64'(bit_cnt), 64'd0);
      beat(27'd4, 1'b1);
      check("st_done_nout", 64'(bus.nout), 64'd4);
      drain();

      // Reset mid-run.
      start(1'b1);
      beat(27'd3, 1'b0);
      beat(27'd3, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_nout", 64'(bus.nout), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_bit_cnt", 64'(bit_cnt), 64'd0);
      check("rst_err", 64'(err_overlen), 64'd0);
      start(1'b0);
      beat(27'h7FF_FFFF, 1'b1);
      check("rst_after_nout", 64'(bus.nout), 64'h7_FFFF_FFFF_FFFF);
      check("rst_after_valid", 64'(bus.out_valid), 64'd1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
